// File: rtl/sprite_mover.sv
// -----------------------------------------------------------------------------
// sprite_mover
// Sprite position controller for the display path. On each frame tick it
// streams an erase pass over the sprite at its current origin, applies a
// bounded vertical move, then streams a draw pass at the new origin. Pixels
// leave through a valid/ready handshake towards the VGA plotter.
//
// Ports
//   clk         system clock
//   reset_n     synchronous, active-low reset
//   tick        frame tick (one-cycle pulse), honoured only when idle
//   y_inc       request origin += STEP (sampled with the tick)
//   y_dec       request origin -= STEP (sampled with the tick)
//   plot_ready  plotter accepts the presented pixel this cycle
//   plot        pixel valid
//   erase       1 = background colour (erase pass), 0 = draw pass
//   x_out       pixel x
//   y_out       pixel y
//   y_pos       committed y origin
//   busy        an update is in progress
//   done        one-cycle pulse when the update completes
// -----------------------------------------------------------------------------
module sprite_mover #(
   parameter int X_W    = 8,
   parameter int Y_W    = 7,
   parameter int SPR_W  = 2,
   parameter int SPR_H  = 4,
   parameter int X_INIT = 155,
   parameter int Y_INIT = 0,
   parameter int Y_MIN  = 0,
   parameter int Y_MAX  = 116,
   parameter int STEP   = 1
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           tick,
   input  logic           y_inc,
   input  logic           y_dec,
   input  logic           plot_ready,
   output logic           plot,
   output logic           erase,
   output logic [X_W-1:0] x_out,
   output logic [Y_W-1:0] y_out,
   output logic [Y_W-1:0] y_pos,
   output logic           busy,
   output logic           done
);

   localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPR_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPR_H - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE,
      S_MOVE,
      S_DRAW,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [Y_W-1:0]   r_ypos;
   logic             r_inc;
   logic             r_dec;
   logic             r_plot;
   logic             r_erase;
   logic [X_W-1:0]   r_x;
   logic [Y_W-1:0]   r_y;
   logic             r_busy;
   logic             r_done;

   state_t           w_state_n;
   logic [COL_W-1:0] w_col_n;
   logic [ROW_W-1:0] w_row_n;
   logic [Y_W-1:0]   w_ypos_n;
   logic             w_inc_n;
   logic             w_dec_n;
   logic             w_accept;
   logic             w_last;

   // Upward move saturating at Y_MAX; the sum is formed at 32 bits so it
   // cannot wrap before the comparison.
   function automatic logic [Y_W-1:0] f_step_up(input logic [Y_W-1:0] y);
      logic [31:0] s;
      s = 32'(y) + 32'(STEP);
      if (s > 32'(Y_MAX))
         return Y_W'(Y_MAX);
      else
         return s[Y_W-1:0];
   endfunction

   // Downward move saturating at Y_MIN; compared before subtracting so the
   // origin can never wrap around to the bottom of the screen.
   function automatic logic [Y_W-1:0] f_step_down(input logic [Y_W-1:0] y);
      if (32'(y) < 32'(Y_MIN) + 32'(STEP))
         return Y_W'(Y_MIN);
      else
         return y - Y_W'(STEP);
   endfunction

   assign w_accept = r_plot && plot_ready;
   assign w_last   = (r_col == COL_LAST) && (r_row == ROW_LAST);

   always_comb begin
      w_state_n = r_state;
      w_col_n   = r_col;
      w_row_n   = r_row;
      w_ypos_n  = r_ypos;
      w_inc_n   = r_inc;
      w_dec_n   = r_dec;
      case (r_state)
         S_IDLE: begin
            if (tick) begin
               w_inc_n   = y_inc;
               w_dec_n   = y_dec;
               w_col_n   = '0;
               w_row_n   = '0;
               w_state_n = S_ERASE;
            end
         end
         S_ERASE, S_DRAW: begin
            // Row-major scan; counters only move on an accepted pixel so a
            // stalled pixel stays on the outputs unchanged.
            if (w_accept) begin
               if (w_last) begin
                  w_col_n   = '0;
                  w_row_n   = '0;
                  w_state_n = (r_state == S_ERASE) ? S_MOVE : S_DONE;
               end else if (r_col == COL_LAST) begin
                  w_col_n = '0;
                  w_row_n = r_row + ROW_W'(1);
               end else begin
                  w_col_n = r_col + COL_W'(1);
               end
            end
         end
         S_MOVE: begin
            case ({r_inc, r_dec})
               2'b10:   w_ypos_n = f_step_up(r_ypos);
               2'b01:   w_ypos_n = f_step_down(r_ypos);
               default: w_ypos_n = r_ypos;
            endcase
            w_col_n   = '0;
            w_row_n   = '0;
            w_state_n = S_DRAW;
         end
         S_DONE:  w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so the first pixel
   // appears the cycle after the tick and the draw pass already sees the
   // updated origin.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_col   <= '0;
         r_row   <= '0;
         r_ypos  <= Y_W'(Y_INIT);
         r_inc   <= 1'b0;
         r_dec   <= 1'b0;
         r_plot  <= 1'b0;
         r_erase <= 1'b0;
         r_x     <= X_W'(X_INIT);
         r_y     <= Y_W'(Y_INIT);
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_col   <= w_col_n;
         r_row   <= w_row_n;
         r_ypos  <= w_ypos_n;
         r_inc   <= w_inc_n;
         r_dec   <= w_dec_n;
         r_plot  <= (w_state_n == S_ERASE) || (w_state_n == S_DRAW);
         r_erase <= (w_state_n == S_ERASE);
         r_x     <= X_W'(X_INIT) + X_W'(w_col_n);
         r_y     <= w_ypos_n + Y_W'(w_row_n);
         r_busy  <= (w_state_n != S_IDLE);
         r_done  <= (w_state_n == S_DONE);
      end
   end

   assign plot  = r_plot;
   assign erase = r_erase;
   assign x_out = r_x;
   assign y_out = r_y;
   assign y_pos = r_ypos;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule

// File: tb/tb_sprite_mover.sv
// -----------------------------------------------------------------------------
// tb_sprite_mover
// Directed bench for sprite_mover with default parameters (2x4 sprite at
// x=155, y in 0..116, step 1) plus a second instance with STEP=3 starting at
// y=115 for the saturating step case.
// -----------------------------------------------------------------------------
module tb_sprite_mover;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick = 1'b0;
   logic       tick3 = 1'b0;
   logic       y_inc = 1'b0;
   logic       y_dec = 1'b0;
   logic       plot_ready = 1'b1;
   logic       plot, erase, busy, done;
   logic [7:0] x_out;
   logic [6:0] y_out, y_pos;
   logic       plot3, erase3, busy3, done3;
   logic [7:0] x_out3;
   logic [6:0] y_out3, y_pos3;

   int vec  = 0;
   int errs = 0;

   // Captured stream of the most recent frame
   logic [7:0] pix_x [0:63];
   logic [6:0] pix_y [0:63];
   logic       pix_e [0:63];
   int         pix_c [0:63];
   int         n_pix, n_done, done_cyc, stall_viol;
   logic       busy_after;

   always #5 clk = ~clk;

   sprite_mover u_dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .y_inc(y_inc), .y_dec(y_dec),
      .plot_ready(plot_ready), .plot(plot), .erase(erase), .x_out(x_out),
      .y_out(y_out), .y_pos(y_pos), .busy(busy), .done(done)
   );

   sprite_mover #(.STEP(3), .Y_INIT(115)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .tick(tick3), .y_inc(y_inc), .y_dec(y_dec),
      .plot_ready(plot_ready), .plot(plot3), .erase(erase3), .x_out(x_out3),
      .y_out(y_out3), .y_pos(y_pos3), .busy(busy3), .done(done3)
   );

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic do_reset();
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   // Stimulus/capture only: issues a tick (cycle 0) and records every accepted
   // pixel, the done pulses and any output change during a stall.
   // mode 1 toggles plot_ready 1,0,1,0 starting at cycle 1.
   task automatic run_frame(input logic inc, input logic dec, input int mode,
                            input int xtick_cyc, input logic late_inc);
      logic [7:0] sx;
      logic [6:0] sy;
      logic       se;
      logic       have_prev;
      int         cyc;
      for (int i = 0; i < 64; i++) begin
         pix_x[i] = 'x; pix_y[i] = 'x; pix_e[i] = 1'bx; pix_c[i] = -1;
      end
      n_pix = 0; n_done = 0; done_cyc = -1; stall_viol = 0; busy_after = 1'bx;
      have_prev = 1'b0; sx = '0; sy = '0; se = 1'b0;
      tick = 1'b1; y_inc = inc; y_dec = dec; plot_ready = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0; y_inc = late_inc; y_dec = 1'b0;
      cyc = 1;
      while (cyc < 200) begin
         tick = (cyc == xtick_cyc);
         plot_ready = (mode == 1) ? (cyc % 2 == 1) : 1'b1;
         if (have_prev && (plot !== 1'b1 || x_out !== sx || y_out !== sy || erase !== se))
            stall_viol++;
         have_prev = (plot === 1'b1) && !plot_ready;
         sx = x_out; sy = y_out; se = erase;
         if (plot === 1'b1 && plot_ready && n_pix < 64) begin
            pix_x[n_pix] = x_out; pix_y[n_pix] = y_out;
            pix_e[n_pix] = erase; pix_c[n_pix] = cyc;
            n_pix++;
         end
         if (done === 1'b1) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
         if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
         @(posedge clk); #1;
         cyc++;
      end
      tick = 1'b0; y_inc = 1'b0; y_dec = 1'b0; plot_ready = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      vec++; if (plot !== 1'b0) begin errs++; $display("FAIL rst_plot: got %b expected 0", plot); end
      vec++; if (erase !== 1'b0) begin errs++; $display("FAIL rst_erase: got %b expected 0", erase); end
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b expected 0", busy); end
      vec++; if (done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b expected 0", done); end
      vec++; if (x_out !== 8'd155) begin errs++; $display("FAIL rst_x: got %0d expected 155", x_out); end
      vec++; if (y_out !== 7'd0) begin errs++; $display("FAIL rst_y: got %0d expected 0", y_out); end
      vec++; if (y_pos !== 7'd0) begin errs++; $display("FAIL rst_ypos: got %0d expected 0", y_pos); end
      vec++; if (y_pos3 !== 7'd115) begin errs++; $display("FAIL rst_ypos3: got %0d expected 115", y_pos3); end
   endtask

   task automatic test_basic();
      int ex, ey, k;
      logic ee;
      run_frame(1'b0, 1'b0, 0, -1, 1'b0);
      vec++; if (n_pix != 16) begin errs++; $display("FAIL basic_npix: got %0d expected 16", n_pix); end
      for (int i = 0; i < 16; i++) begin
         k = i % 8; ee = (i < 8); ex = 155 + k % 2; ey = k / 2;
         vec++;
         if (pix_x[i] !== 8'(ex) || pix_y[i] !== 7'(ey) || pix_e[i] !== ee) begin
            errs++;
            $display("FAIL basic_pix%0d: got (%0d,%0d,e%b) expected (%0d,%0d,e%b)",
                     i, pix_x[i], pix_y[i], pix_e[i], ex, ey, ee);
         end
      end
      vec++; if (pix_c[0] != 1) begin errs++; $display("FAIL basic_first_cyc: got %0d expected 1", pix_c[0]); end
      vec++; if (pix_c[7] != 8) begin errs++; $display("FAIL basic_last_erase_cyc: got %0d expected 8", pix_c[7]); end
      vec++; if (pix_c[8] != 10) begin errs++; $display("FAIL basic_first_draw_cyc: got %0d expected 10", pix_c[8]); end
      vec++; if (done_cyc != 18) begin errs++; $display("FAIL basic_done_cyc: got %0d expected 18", done_cyc); end
      vec++; if (n_done != 1) begin errs++; $display("FAIL basic_ndone: got %0d expected 1", n_done); end
      vec++; if (busy_after !== 1'b0) begin errs++; $display("FAIL basic_busy_after: got %b expected 0", busy_after); end
      vec++; if (y_pos !== 7'd0) begin errs++; $display("FAIL basic_ypos: got %0d expected 0", y_pos); end
   endtask

   task automatic test_inc_frames();
      int ex, ey, k;
      logic ee;
      for (int f = 1; f <= 5; f++) begin
         run_frame(1'b1, 1'b0, 0, -1, 1'b0);
         vec++; if (y_pos !== 7'(f)) begin errs++; $display("FAIL inc_ypos_f%0d: got %0d expected %0d", f, y_pos, f); end
         vec++; if (n_pix != 16) begin errs++; $display("FAIL inc_npix_f%0d: got %0d expected 16", f, n_pix); end
         for (int i = 0; i < 16; i++) begin
            k = i % 8; ee = (i < 8); ex = 155 + k % 2; ey = (ee ? f - 1 : f) + k / 2;
            vec++;
            if (pix_x[i] !== 8'(ex) || pix_y[i] !== 7'(ey) || pix_e[i] !== ee) begin
               errs++;
               $display("FAIL inc_f%0d_pix%0d: got (%0d,%0d,e%b) expected (%0d,%0d,e%b)",
                        f, i, pix_x[i], pix_y[i], pix_e[i], ex, ey, ee);
            end
         end
      end
   endtask

   task automatic test_both();
      run_frame(1'b1, 1'b1, 0, -1, 1'b0);
      vec++; if (y_pos !== 7'd5) begin errs++; $display("FAIL both_ypos: got %0d expected 5", y_pos); end
      vec++; if (pix_y[8] !== 7'd5 || pix_y[15] !== 7'd8) begin
         errs++; $display("FAIL both_draw_rows: got %0d..%0d expected 5..8", pix_y[8], pix_y[15]);
      end
   endtask

   task automatic test_back_to_back();
      // Second tick at cycle 5 while busy and y_inc raised after the tick:
      // neither may affect the update in progress.
      run_frame(1'b0, 1'b0, 0, 5, 1'b1);
      vec++; if (n_done != 1) begin errs++; $display("FAIL b2b_ndone: got %0d expected 1", n_done); end
      vec++; if (n_pix != 16) begin errs++; $display("FAIL b2b_npix: got %0d expected 16", n_pix); end
      vec++; if (done_cyc != 18) begin errs++; $display("FAIL b2b_done_cyc: got %0d expected 18", done_cyc); end
      vec++; if (y_pos !== 7'd5) begin errs++; $display("FAIL b2b_ypos: got %0d expected 5", y_pos); end
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_stall();
      int ex, ey, k;
      logic ee;
      run_frame(1'b0, 1'b0, 1, -1, 1'b0);
      vec++; if (n_pix != 16) begin errs++; $display("FAIL stall_npix: got %0d expected 16", n_pix); end
      for (int i = 0; i < 16; i++) begin
         k = i % 8; ee = (i < 8); ex = 155 + k % 2; ey = 5 + k / 2;
         vec++;
         if (pix_x[i] !== 8'(ex) || pix_y[i] !== 7'(ey) || pix_e[i] !== ee) begin
            errs++;
            $display("FAIL stall_pix%0d: got (%0d,%0d,e%b) expected (%0d,%0d,e%b)",
                     i, pix_x[i], pix_y[i], pix_e[i], ex, ey, ee);
         end
      end
      vec++; if (stall_viol != 0) begin errs++; $display("FAIL stall_hold: got %0d changes expected 0", stall_viol); end
      vec++; if (done_cyc != 32) begin errs++; $display("FAIL stall_done_cyc: got %0d expected 32", done_cyc); end
      vec++; if (n_done != 1) begin errs++; $display("FAIL stall_ndone: got %0d expected 1", n_done); end
   endtask

   task automatic test_clamp();
      int ex, ey, k, guard;
      logic ee;
      guard = 0;
      while (y_pos !== 7'd116 && guard < 200) begin
         run_frame(1'b1, 1'b0, 0, -1, 1'b0);
         guard++;
      end
      vec++; if (y_pos !== 7'd116) begin errs++; $display("FAIL clamp_reach: got %0d expected 116", y_pos); end
      vec++; if (guard != 111) begin errs++; $display("FAIL clamp_frames: got %0d expected 111", guard); end
      run_frame(1'b1, 1'b0, 0, -1, 1'b0);
      vec++; if (y_pos !== 7'd116) begin errs++; $display("FAIL clamp_top: got %0d expected 116", y_pos); end
      for (int i = 0; i < 16; i++) begin
         k = i % 8; ee = (i < 8); ex = 155 + k % 2; ey = 116 + k / 2;
         vec++;
         if (pix_x[i] !== 8'(ex) || pix_y[i] !== 7'(ey) || pix_e[i] !== ee) begin
            errs++;
            $display("FAIL clamp_top_pix%0d: got (%0d,%0d,e%b) expected (%0d,%0d,e%b)",
                     i, pix_x[i], pix_y[i], pix_e[i], ex, ey, ee);
         end
      end
      do_reset();
      run_frame(1'b0, 1'b1, 0, -1, 1'b0);
      vec++; if (y_pos !== 7'd0) begin errs++; $display("FAIL clamp_bottom: got %0d expected 0", y_pos); end
      vec++; if (pix_y[8] !== 7'd0 || pix_y[15] !== 7'd3) begin
         errs++; $display("FAIL clamp_bottom_rows: got %0d..%0d expected 0..3", pix_y[8], pix_y[15]);
      end
      run_frame(1'b1, 1'b0, 0, -1, 1'b0);
      run_frame(1'b1, 1'b0, 0, -1, 1'b0);
      run_frame(1'b0, 1'b1, 0, -1, 1'b0);
      vec++; if (y_pos !== 7'd1) begin errs++; $display("FAIL dec_normal: got %0d expected 1", y_pos); end
   endtask

   task automatic test_step3();
      int cnt;
      cnt = 0;
      tick3 = 1'b1; y_inc = 1'b1;
      @(posedge clk); #1;
      tick3 = 1'b0; y_inc = 1'b0;
      while (done3 !== 1'b1 && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      vec++; if (done3 !== 1'b1) begin errs++; $display("FAIL step3_done: got %b expected 1 within 40 cycles", done3); end
      vec++; if (y_pos3 !== 7'd116) begin errs++; $display("FAIL step3_ypos: got %0d expected 116", y_pos3); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int ex, ey, k;
      logic ee;
      tick = 1'b1; y_inc = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0; y_inc = 1'b0;
      repeat (11) begin @(posedge clk); #1; end
      vec++; if (plot !== 1'b1 || erase !== 1'b0) begin
         errs++; $display("FAIL mid_in_draw: got plot=%b erase=%b expected plot=1 erase=0", plot, erase);
      end
      do_reset();
      vec++; if (plot !== 1'b0) begin errs++; $display("FAIL mid_rst_plot: got %b expected 0", plot); end
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
      vec++; if (y_pos !== 7'd0) begin errs++; $display("FAIL mid_rst_ypos: got %0d expected 0", y_pos); end
      run_frame(1'b0, 1'b0, 0, -1, 1'b0);
      vec++; if (n_pix != 16) begin errs++; $display("FAIL mid_next_npix: got %0d expected 16", n_pix); end
      for (int i = 0; i < 16; i++) begin
         k = i % 8; ee = (i < 8); ex = 155 + k % 2; ey = k / 2;
         vec++;
         if (pix_x[i] !== 8'(ex) || pix_y[i] !== 7'(ey) || pix_e[i] !== ee) begin
            errs++;
            $display("FAIL mid_next_pix%0d: got (%0d,%0d,e%b) expected (%0d,%0d,e%b)",
                     i, pix_x[i], pix_y[i], pix_e[i], ex, ey, ee);
         end
      end
      vec++; if (done_cyc != 18) begin errs++; $display("FAIL mid_next_done_cyc: got %0d expected 18", done_cyc); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_inc_frames();
      test_both();
      test_back_to_back();
      test_stall();
      test_clamp();
      test_step3();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
